dump_uart_tx: RTL

DUMP_UART_TX -- requirements
Module: dump_uart_tx

---
 rtl/dump_uart_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dump_uart_tx.sv
// dump_uart_tx: serialises a register-dump frame (0xA5, r1, r2, r3 little-endian)
// or a single 'H' halt byte over an 8N1 UART line, CLKS_PER_BIT clocks per bit.
// Ports: clk/reset (sync, active high); dump = level dump request; halt = CPU
//   halted; r1..r3 = values captured on the request edge; tx = serial line
//   (idle high); busy = transmission in progress; overflow = sticky lost-request flag.
// Latency: tx drops to the start bit on the capture edge; bytes are back-to-back.
// Backpressure: none; a dump request seen while busy is dropped and flagged.
// Optional feature: define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module dump_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dump,
  input  logic        halt,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

`ifdef DUMP_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif
  localparam logic [7:0]  HDR       = 8'hA5;
  localparam logic [7:0]  HALT_CHAR = 8'h48;
  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [3:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  cur_byte;
  logic [31:0] r1_q, r2_q, r3_q;
  logic        halt_sent;
  logic        in_halt;      // current byte is the lone 'H', not part of a frame
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]  csum;         // running XOR of every frame byte loaded so far
`endif

  logic        bit_done;
  logic [3:0]  next_idx;
  logic [3:0]  pidx;
  logic [31:0] word_sel;
  logic [7:0]  next_byte;

  assign bit_done = (clk_cnt == CNT_MAX);
  assign next_idx = byte_idx + 4'd1;

  // Frame byte k (1..12) is byte (k-1)%4 of word (k-1)/4 of the snapshot.
  always_comb begin
    pidx = next_idx - 4'd1;
    case (pidx[3:2])
      2'd0:    word_sel = r1_q;
      2'd1:    word_sel = r2_q;
      default: word_sel = r3_q;
    endcase
    next_byte = word_sel[{pidx[1:0], 3'b000} +: 8];
`ifdef DUMP_CHECKSUM_EN
    if (next_idx == LAST_IDX) next_byte = csum;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      cur_byte  <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      halt_sent <= 1'b0;
      in_halt   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // busy is still low on the capture edge, so only later requests count.
      if (dump && busy) overflow <= 1'b1;

      if (state != IDLE) clk_cnt <= bit_done ? '0 : clk_cnt + 16'd1;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (dump) begin
            r1_q     <= r1;
            r2_q     <= r2;
            r3_q     <= r3;
            cur_byte <= HDR;
            byte_idx <= '0;
            in_halt  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= HDR;
`endif
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end else if (halt && !halt_sent) begin
            cur_byte  <= HALT_CHAR;
            in_halt   <= 1'b1;
            halt_sent <= 1'b1;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end

        STOP: begin
          if (bit_done) begin
            if (!in_halt && byte_idx != LAST_IDX) begin
              byte_idx <= next_idx;
              cur_byte <= next_byte;
`ifdef DUMP_CHECKSUM_EN
              csum     <= csum ^ next_byte;
`endif
              state    <= START;
              tx       <= 1'b0;
            end else if (!in_halt && halt && !halt_sent) begin
              // Pending halt chains straight onto the end of the dump frame.
              cur_byte  <= HALT_CHAR;
              in_halt   <= 1'b1;
              halt_sent <= 1'b1;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
